// File: rtl/branch_predict_unit_if.sv
// Fetch lookup and execute resolution signals of the branch predict unit.
// slave = predictor side, master = pipeline side.
interface branch_predict_unit_if #(
    parameter int PC_W = 9
);
    logic [PC_W-1:0] F_PC;
    logic            Pred_Taken;
    logic [31:0]     Pred_Target;
    logic            Ex_Valid;
    logic [PC_W-1:0] Cur_PC;
    logic [31:0]     Imm;
    logic            Branch;
    logic            JaltoReg;
    logic            JalrSel;
    logic            Halt;
    logic [31:0]     AluResult;
    logic            Ex_PredTaken;
    logic [31:0]     Ex_PredTarget;
    logic [31:0]     PC_Imm;
    logic [31:0]     PC_Four;
    logic [31:0]     BrPC;
    logic            PcSel;
    logic            Mispredict;
    logic [15:0]     Mispredict_Cnt;

    modport slave (
        input  F_PC, Ex_Valid, Cur_PC, Imm, Branch, JaltoReg, JalrSel, Halt,
               AluResult, Ex_PredTaken, Ex_PredTarget,
        output Pred_Taken, Pred_Target, PC_Imm, PC_Four, BrPC, PcSel,
               Mispredict, Mispredict_Cnt
    );

    modport master (
        output F_PC, Ex_Valid, Cur_PC, Imm, Branch, JaltoReg, JalrSel, Halt,
               AluResult, Ex_PredTaken, Ex_PredTarget,
        input  Pred_Taken, Pred_Target, PC_Imm, PC_Four, BrPC, PcSel,
               Mispredict, Mispredict_Cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: same-cycle fetch prediction,
// execute-stage resolution that redirects only on mispredict or halt.
module branch_predict_unit #(
    parameter int         PC_W     = 9,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input logic                  clk,
    input logic                  reset,
    branch_predict_unit_if.slave bus
);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam int DEPTH = 2 ** IDX_W;

    logic              r_valid  [DEPTH];
    logic [TAG_W-1:0]  r_tag    [DEPTH];
    logic [PC_W-1:0]   r_target [DEPTH];
    logic [1:0]        r_cnt    [DEPTH];
    logic [15:0]       r_mcnt;

    logic [IDX_W-1:0]  w_f_idx;
    logic [TAG_W-1:0]  w_f_tag;
    logic              w_f_hit;
    logic              w_pred_taken;
    logic [IDX_W-1:0]  w_e_idx;
    logic [TAG_W-1:0]  w_e_tag;
    logic              w_e_hit;
    logic [31:0]       w_pc_full;
    logic [31:0]       w_pc_imm;
    logic [31:0]       w_pc_four;
    logic              w_act_taken;
    logic              w_mispredict;
    logic              w_update;
    logic [1:0]        w_cnt_inc;
    logic [1:0]        w_cnt_dec;

    always_comb begin
        w_f_idx      = bus.F_PC[IDX_W+1:2];
        w_f_tag      = bus.F_PC[PC_W-1:IDX_W+2];
        w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
        w_pred_taken = !reset && w_f_hit && r_cnt[w_f_idx][1];

        bus.Pred_Taken  = w_pred_taken;
        bus.Pred_Target = w_pred_taken ? {{(32-PC_W){1'b0}}, r_target[w_f_idx]}
                                       : {{(32-PC_W){1'b0}}, bus.F_PC} + 32'd4;
    end

    always_comb begin
        w_pc_full   = {{(32-PC_W){1'b0}}, bus.Cur_PC};
        w_pc_four   = w_pc_full + 32'd4;
        w_pc_imm    = bus.JalrSel ? bus.AluResult : w_pc_full + bus.Imm;
        w_act_taken = bus.JaltoReg || (bus.Branch && bus.AluResult[0]);
        // Only the low PC_W target bits are architecturally meaningful.
        w_mispredict = bus.Ex_Valid && !bus.Halt &&
                       ((w_act_taken != bus.Ex_PredTaken) ||
                        (w_act_taken && (bus.Ex_PredTarget[PC_W-1:0] != w_pc_imm[PC_W-1:0])));

        if (bus.Ex_Valid && bus.Halt) begin
            bus.BrPC = w_pc_full;
        end else if (w_mispredict) begin
            bus.BrPC = w_act_taken ? w_pc_imm : w_pc_four;
        end else begin
            bus.BrPC = '0;
        end

        bus.PC_Imm         = w_pc_imm;
        bus.PC_Four        = w_pc_four;
        bus.PcSel          = bus.Ex_Valid && (bus.Halt || w_mispredict);
        bus.Mispredict     = w_mispredict;
        bus.Mispredict_Cnt = r_mcnt;
    end

    always_comb begin
        w_e_idx   = bus.Cur_PC[IDX_W+1:2];
        w_e_tag   = bus.Cur_PC[PC_W-1:IDX_W+2];
        w_e_hit   = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
        w_update  = bus.Ex_Valid && !bus.Halt && (bus.Branch || bus.JaltoReg);
        w_cnt_inc = (r_cnt[w_e_idx] == 2'b11) ? 2'b11 : r_cnt[w_e_idx] + 2'd1;
        w_cnt_dec = (r_cnt[w_e_idx] == 2'b00) ? 2'b00 : r_cnt[w_e_idx] - 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_INIT;
            end
        end else if (w_update) begin
            if (w_e_hit) begin
                if (w_act_taken) begin
                    r_cnt[w_e_idx]    <= bus.JaltoReg ? 2'b11 : w_cnt_inc;
                    r_target[w_e_idx] <= w_pc_imm[PC_W-1:0];
                end else begin
                    r_cnt[w_e_idx] <= w_cnt_dec;
                end
            end else if (w_act_taken) begin
                r_valid[w_e_idx]  <= 1'b1;
                r_tag[w_e_idx]    <= w_e_tag;
                r_target[w_e_idx] <= w_pc_imm[PC_W-1:0];
                r_cnt[w_e_idx]    <= bus.JaltoReg ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcnt <= '0;
        end else if (w_mispredict && (r_mcnt != 16'hFFFF)) begin
            r_mcnt <= r_mcnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed plan steps, then
// randomized traffic against an arithmetic model of the predictor table.
module tb_branch_predict_unit;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    branch_predict_unit_if #(.PC_W(9)) bif ();

    branch_predict_unit #(
        .PC_W(9),
        .IDX_W(4),
        .CNT_INIT(2'b01)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model of the table, indexed by (pc / 4) mod 16, tagged by pc / 64
    int m_valid  [16];
    int m_tag    [16];
    int m_target [16];
    int m_cnt    [16];
    int m_mcnt;

    logic        e_pt;
    logic [31:0] e_ptgt;
    logic [31:0] e_imm;
    logic [31:0] e_four;
    logic [31:0] e_brpc;
    logic        e_pcsel;
    logic        e_misp;
    logic        e_act;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1;
        end
        m_mcnt = 0;
    endtask

    task automatic lookup(input int pc, output logic taken, output logic [31:0] tgt);
        int idx;
        int tag;
        idx   = (pc / 4) % 16;
        tag   = pc / 64;
        taken = (m_valid[idx] != 0) && (m_tag[idx] == tag) && (m_cnt[idx] >= 2);
        tgt   = taken ? 32'(m_target[idx]) : 32'(pc + 4);
    endtask

    task automatic expect_calc();
        logic [31:0] pcf;
        pcf = 32'(int'(bif.Cur_PC));
        lookup(int'(bif.F_PC), e_pt, e_ptgt);
        if (reset) begin
            e_pt   = 1'b0;
            e_ptgt = 32'(int'(bif.F_PC) + 4);
        end
        e_four = pcf + 32'd4;
        e_imm  = bif.JalrSel ? bif.AluResult : pcf + bif.Imm;
        e_act  = bif.JaltoReg || (bif.Branch && bif.AluResult[0]);
        e_misp = bif.Ex_Valid && !bif.Halt &&
                 ((e_act != bif.Ex_PredTaken) ||
                  (e_act && ((bif.Ex_PredTarget % 512) != (e_imm % 512))));
        if (bif.Ex_Valid && bif.Halt) e_brpc = pcf;
        else if (e_misp)              e_brpc = e_act ? e_imm : e_four;
        else                          e_brpc = 32'd0;
        e_pcsel = bif.Ex_Valid && (bif.Halt || e_misp);
    endtask

    task automatic model_train();
        int idx;
        int tag;
        bit hit;
        expect_calc();
        if (bif.Ex_Valid && !bif.Halt && (bif.Branch || bif.JaltoReg)) begin
            idx = (int'(bif.Cur_PC) / 4) % 16;
            tag = int'(bif.Cur_PC) / 64;
            hit = (m_valid[idx] != 0) && (m_tag[idx] == tag);
            if (hit && e_act) begin
                m_cnt[idx]    = bif.JaltoReg ? 3 : ((m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3);
                m_target[idx] = int'(e_imm % 512);
            end else if (hit) begin
                m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
            end else if (e_act) begin
                m_valid[idx]  = 1;
                m_tag[idx]    = tag;
                m_target[idx] = int'(e_imm % 512);
                m_cnt[idx]    = bif.JaltoReg ? 3 : 2;
            end
        end
        if (e_misp && m_mcnt < 65535) m_mcnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #2;
        expect_calc();
        chk({tag, ".Pred_Taken"},  32'(bif.Pred_Taken),     32'(e_pt));
        chk({tag, ".Pred_Target"}, bif.Pred_Target,         e_ptgt);
        chk({tag, ".PC_Imm"},      bif.PC_Imm,              e_imm);
        chk({tag, ".PC_Four"},     bif.PC_Four,             e_four);
        chk({tag, ".BrPC"},        bif.BrPC,                e_brpc);
        chk({tag, ".PcSel"},       32'(bif.PcSel),          32'(e_pcsel));
        chk({tag, ".Mispredict"},  32'(bif.Mispredict),     32'(e_misp));
        chk({tag, ".MispCnt"},     32'(bif.Mispredict_Cnt), 32'(m_mcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_train();
        #1;
    endtask

    task automatic drive(input logic ev, input int cur, input logic [31:0] imm,
                         input logic br, input logic jal, input logic jsel,
                         input logic halt, input logic [31:0] alu,
                         input logic pt, input logic [31:0] ptgt, input int fpc);
        bif.Ex_Valid      = ev;
        bif.Cur_PC        = 9'(cur);
        bif.Imm           = imm;
        bif.Branch        = br;
        bif.JaltoReg      = jal;
        bif.JalrSel       = jsel;
        bif.Halt          = halt;
        bif.AluResult     = alu;
        bif.Ex_PredTaken  = pt;
        bif.Ex_PredTarget = ptgt;
        bif.F_PC          = 9'(fpc);
    endtask

    initial begin
        logic        r_pt;
        logic [31:0] r_tgt;
        int          cur;
        compared   = 0;
        mismatched = 0;
        model_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h010);

        // 1: reset state
        check_all("reset");
        chk("reset.Pred_Target_const", bif.Pred_Target, 32'h14);
        tick(); tick();
        reset = 1'b0;
        tick();

        // 2: taken branch predicted not-taken, then learned
        drive(1, 'h010, 32'h20, 1, 0, 0, 0, 32'h1, 0, 0, 'h010);
        check_all("t2");
        chk("t2.BrPC_const", bif.BrPC, 32'h30);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h010);
        check_all("t2b");
        chk("t2b.Pred_Taken_const", 32'(bif.Pred_Taken), 32'd1);
        chk("t2b.Pred_Target_const", bif.Pred_Target, 32'h30);
        tick();

        // 3: not-taken twice
        drive(1, 'h010, 32'h20, 1, 0, 0, 0, 32'h0, 1, 32'h30, 'h010);
        check_all("t3a");
        chk("t3a.BrPC_const", bif.BrPC, 32'h14);
        tick();
        drive(1, 'h010, 32'h20, 1, 0, 0, 0, 32'h0, 0, 32'h14, 'h010);
        check_all("t3b");
        tick();
        chk("t3.MispCnt_const", 32'(bif.Mispredict_Cnt), 32'd2);

        // 4: jalr with wrong target, then replay
        drive(1, 'h040, 32'h0, 0, 1, 1, 0, 32'h100, 1, 32'h080, 'h040);
        check_all("t4a");
        chk("t4a.BrPC_const", bif.BrPC, 32'h100);
        tick();
        drive(1, 'h040, 32'h0, 0, 1, 1, 0, 32'h100, 1, 32'h100, 'h040);
        check_all("t4b");
        chk("t4b.PcSel_const", 32'(bif.PcSel), 32'd0);
        tick();

        // 5: halt and bubble
        drive(1, 'h0FC, 32'h8, 1, 0, 0, 1, 32'h1, 0, 0, 'h0FC);
        check_all("t5a");
        chk("t5a.BrPC_const", bif.BrPC, 32'h0FC);
        tick();
        drive(0, 'h0FC, 32'h8, 1, 0, 0, 0, 32'h1, 0, 0, 'h0FC);
        check_all("t5b");
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0FC);
        check_all("t5c");
        tick();

        // 6: aliasing, then reset during an update
        drive(1, 'h050, 32'h8, 1, 0, 0, 0, 32'h1, 0, 0, 'h050);
        check_all("t6a");
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h010);
        check_all("t6b");
        chk("t6b.alias_miss", 32'(bif.Pred_Taken), 32'd0);
        tick();
        drive(1, 'h020, 32'h40, 1, 0, 0, 0, 32'h1, 0, 0, 'h050);
        #1;
        reset = 1'b1;
        model_reset();
        check_all("t6c");
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h020);
        check_all("t6d");
        chk("t6d.dropped_update", 32'(bif.Pred_Taken), 32'd0);
        tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                              : int'($urandom_range(0, 127)) * 4;
            lookup(cur, r_pt, r_tgt);
            if ($urandom_range(0, 3) == 0) begin
                r_pt  = 1'($urandom);
                r_tgt = $urandom;
            end
            drive(($urandom_range(0, 9) != 0), cur,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'(int'($urandom_range(0, 255)) - 128),
                  1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
                  ($urandom_range(0, 9) == 0), $urandom, r_pt, r_tgt,
                  ($urandom_range(0, 1) == 0) ? cur : int'($urandom_range(0, 511)));
            check_all("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the single-cycle branch resolver. It adds a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. Fetch-stage lookup predicts taken/target in the same cycle; execute-stage resolution compares the actual outcome with the prediction carried down the pipeline and redirects only on mispredict or halt. The table trains on every resolved control instruction and keeps a mispredict statistic.

Parameters:
PC_W, 9, width of the program counter; PCs are zero-extended to 32 bits.
IDX_W, 4, BTB index width (2^IDX_W entries); index = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2]; requires PC_W >= IDX_W+3.
CNT_INIT, 2'b01, reset value of every direction counter (weakly not-taken).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
F_PC  in  PC_W  fetch-stage PC for lookup
Pred_Taken  out  1  fetch prediction: taken
Pred_Target  out  32  predicted next fetch PC
Ex_Valid  in  1  execute-stage slot holds a real instruction (0 = bubble)
Cur_PC  in  PC_W  PC of the instruction in execute
Imm  in  32  sign-extended immediate
Branch  in  1  conditional branch
JaltoReg  in  1  jal/jalr (unconditional)
JalrSel  in  1  target taken from AluResult (jalr)
Halt  in  1  halt instruction in execute
AluResult  in  32  bit0 = branch condition; full value = jalr target
Ex_PredTaken  in  1  Pred_Taken carried with this instruction
Ex_PredTarget  in  32  Pred_Target carried with this instruction
PC_Imm  out  32  JalrSel ? AluResult : PC_Full+Imm
PC_Four  out  32  PC_Full+4
BrPC  out  32  redirect PC
PcSel  out  1  1 = fetch takes BrPC
Mispredict  out  1  redirect caused by misprediction
Mispredict_Cnt  out  16  saturating mispredict count

Behaviour:
- Entry state: valid, tag, target[PC_W-1:0], cnt[1:0].
- Lookup is combinational: hit = valid && tag match.
  - Pred_Taken = hit && cnt[1].
  - Pred_Target = Pred_Taken ? zero-extended target : F_PC+4 (32-bit).
- Resolution is combinational. PC_Full = zero-extended Cur_PC; 32-bit adds wrap mod 2^32.
  - ActTaken = JaltoReg || (Branch && AluResult[0]).
- Mispredict = Ex_Valid && !Halt && (ActTaken != Ex_PredTaken || (ActTaken && Ex_PredTarget[PC_W-1:0] != PC_Imm[PC_W-1:0])). Target bits above PC_W are ignored.
- BrPC priority:
  - Ex_Valid && Halt -> PC_Full.
  - Mispredict && ActTaken -> PC_Imm.
  - Mispredict && !ActTaken -> PC_Four.
  - Otherwise 0.
- PcSel = Ex_Valid && (Halt || Mispredict). Correct predictions never redirect.
- Update is at posedge when Ex_Valid && !Halt && (Branch || JaltoReg), at index/tag of Cur_PC:
  - Hit: taken -> cnt saturating +1, target <= PC_Imm[PC_W-1:0]; not taken -> cnt saturating -1, target unchanged.
  - Miss and taken: allocate/overwrite with valid=1, new tag, target, cnt=2'b10.
  - Miss and not taken: no write.
  - JaltoReg: cnt forced to 2'b11 on every update.
- Same-index read and write in one cycle: lookup returns the pre-update entry; the new value is visible the next cycle.
- Mispredict_Cnt increments at posedge when Mispredict = 1 and holds at 16'hFFFF.
- Halt and bubbles: no table update, no count.
- Reset (async, any time):
  - All valid = 0, cnt = CNT_INIT, tag/target = 0, Mispredict_Cnt = 0.
  - An update in the same cycle is dropped.
  - While reset is held: Pred_Taken = 0, Pred_Target = F_PC+4; resolution outputs remain combinational.
- Latency: prediction 0 cycles; redirect 0 cycles after execute; training visible 1 cycle later.

Test Plan:
1. Reset, F_PC=0x010 -> Pred_Taken=0, Pred_Target=0x14; Mispredict_Cnt=0.
2. Branch at Cur_PC=0x010, Imm=0x20, AluResult[0]=1, Ex_PredTaken=0 -> PcSel=1, Mispredict=1, BrPC=0x30. Next cycle, F_PC=0x010 -> Pred_Taken=1, Pred_Target=0x30; Mispredict_Cnt=1.
3. Same branch resolved not-taken twice with Ex_PredTaken=1 -> first: BrPC=0x14, cnt 10->01; second: Ex_PredTaken=0 predicted, no redirect, cnt 01->00; Mispredict_Cnt +1 only for the first.
4. jalr at Cur_PC=0x040, AluResult=0x100, Ex_PredTaken=1, Ex_PredTarget=0x080 -> Mispredict=1, BrPC=0x100. Retrain, replay -> no redirect.
5. Halt with Cur_PC=0x0FC, Branch=1 -> PcSel=1, BrPC=0x0FC, Mispredict=0, no table write. Ex_Valid=0 with Branch=1 -> PcSel=0, no update.
6. Aliasing PCs 0x010 and 0x050 (same index, different tag): train 0x050 taken -> 0x010 lookup misses. Assert reset mid-update -> entry stays invalid.
